// File: rtl/pe_host_pkg.sv
// Shared types for the host-side PE array command initiator.
package pe_host_pkg;

   // Host request operations as carried on req_op.
   typedef enum logic [1:0] {
      HOST_WRITE = 2'd0,
      HOST_READ  = 2'd1,
      HOST_FILL  = 2'd2,
      HOST_STEP  = 2'd3
   } host_op_e;

   // Controller sequencing states.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_GAP,
      ST_RESP
   } host_state_e;

   // Array command encodings; these must track the pe_array opcode decoder.
   localparam logic [1:0] PE_NOP   = 2'd0;
   localparam logic [1:0] PE_WRITE = 2'd1;
   localparam logic [1:0] PE_READ  = 2'd2;
   localparam logic [1:0] PE_STEP  = 2'd3;

   // Array command issued for a host op (FILL is a sequence of writes).
   function automatic logic [1:0] pe_cmd(host_op_e op);
      case (op)
         HOST_READ: return PE_READ;
         HOST_STEP: return PE_STEP;
         default:   return PE_WRITE;
      endcase
   endfunction

endpackage

// File: rtl/pe_fill_counter.sv
// Raster x/y cell counter for whole-array fill: x fastest, y outer.
module pe_fill_counter #(
   parameter int X_BITS = 5,
   parameter int Y_BITS = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              adv,
   output logic [X_BITS-1:0] x,
   output logic [Y_BITS-1:0] y,
   output logic              last
);

   // Advance in raster order; x wrapping to 0 carries into y.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x <= '0;
         y <= '0;
      end else if (clr) begin
         x <= '0;
         y <= '0;
      end else if (adv) begin
         x <= x + 1'b1;
         if (&x) y <= y + 1'b1;
      end
   end

   // Last cell is the far corner of the array.
   always_comb last = (&x) && (&y);

endmodule

// File: rtl/pe_host_ctrl.sv
// Host command initiator for the PE array cell-access port. Serialises
// single-cell write/read, whole-array fill and generation step commands,
// and reports read data plus timeout status on a one-cycle response strobe.
module pe_host_ctrl
   import pe_host_pkg::*;
#(
   parameter int N_PX_BITS     = 5,
   parameter int N_PY_BITS     = 5,
   parameter int PE_CMD_BITS   = 2,
   parameter int PE_STATE_BITS = 1,
   parameter int TIMEOUT_CYC   = 1024
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [1:0]               req_op,
   input  logic [N_PX_BITS-1:0]     req_x,
   input  logic [N_PY_BITS-1:0]     req_y,
   input  logic [PE_STATE_BITS-1:0] req_data,
   output logic                     rsp_valid,
   output logic [PE_STATE_BITS-1:0] rsp_data,
   output logic                     rsp_err,
   output logic [N_PX_BITS-1:0]     adr_x,
   output logic [N_PY_BITS-1:0]     adr_y,
   output logic [PE_CMD_BITS-1:0]   opcode,
   output logic [PE_STATE_BITS-1:0] vali,
   input  logic [PE_STATE_BITS-1:0] valo,
   input  logic                     written
);

   localparam int              TMO_W   = $clog2(TIMEOUT_CYC) + 1;
   localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYC - 1);

   host_state_e              state, state_nxt;
   host_op_e                 op_q;
   logic [N_PX_BITS-1:0]     x_q;
   logic [N_PY_BITS-1:0]     y_q;
   logic [PE_STATE_BITS-1:0] data_q;
   logic [PE_STATE_BITS-1:0] rdata_q;
   logic                     err_q;
   logic [TMO_W-1:0]         tmo_q;

   logic                     accept;
   logic                     fill_adv;
   logic [N_PX_BITS-1:0]     fc_x;
   logic [N_PY_BITS-1:0]     fc_y;
   logic                     fc_last;

   pe_fill_counter #(
      .X_BITS (N_PX_BITS),
      .Y_BITS (N_PY_BITS)
   ) u_fill (
      .clk  (clk),
      .rst  (rst),
      .clr  (accept),
      .adv  (fill_adv),
      .x    (fc_x),
      .y    (fc_y),
      .last (fc_last)
   );

   // State register plus captured request, timeout counter and response data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         op_q    <= HOST_WRITE;
         x_q     <= '0;
         y_q     <= '0;
         data_q  <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         tmo_q   <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            op_q    <= host_op_e'(req_op);
            x_q     <= req_x;
            y_q     <= req_y;
            data_q  <= req_data;
            rdata_q <= '0;
            err_q   <= 1'b0;
         end
         if (state == ST_ISSUE) tmo_q <= '0;
         if (state == ST_WAIT) begin
            if (written) begin
               if (op_q == HOST_READ) rdata_q <= valo;
            end else begin
               tmo_q <= tmo_q + 1'b1;
               if (tmo_q == TMO_MAX) err_q <= 1'b1;
            end
         end
      end
   end

   // Next-state and output decode. Array outputs are a pure function of the
   // state and captured request, so an async reset drops them at once.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      fill_adv  = 1'b0;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      rsp_data  = '0;
      rsp_err   = 1'b0;
      adr_x     = '0;
      adr_y     = '0;
      opcode    = PE_CMD_BITS'(PE_NOP);
      vali      = '0;

      // Address/data stay stable through ISSUE, WAIT and GAP of each cell.
      if (state == ST_ISSUE || state == ST_WAIT || state == ST_GAP) begin
         case (op_q)
            HOST_FILL: begin
               adr_x = fc_x;
               adr_y = fc_y;
               vali  = data_q;
            end
            HOST_WRITE: begin
               adr_x = x_q;
               adr_y = y_q;
               vali  = data_q;
            end
            HOST_READ: begin
               adr_x = x_q;
               adr_y = y_q;
            end
            default: ;
         endcase
      end
      if (state == ST_ISSUE || state == ST_WAIT)
         opcode = PE_CMD_BITS'(pe_cmd(op_q));

      case (state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               accept    = 1'b1;
               state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: state_nxt = ST_WAIT;
         ST_WAIT: begin
            if (written || tmo_q == TMO_MAX) state_nxt = ST_GAP;
         end
         // NOP gap held until the array releases written.
         ST_GAP: begin
            if (!written) begin
               if (op_q == HOST_FILL && !err_q && !fc_last) begin
                  fill_adv  = 1'b1;
                  state_nxt = ST_ISSUE;
               end else begin
                  state_nxt = ST_RESP;
               end
            end
         end
         ST_RESP: begin
            rsp_valid = 1'b1;
            rsp_data  = rdata_q;
            rsp_err   = err_q;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_pe_host_ctrl.sv
// Directed bench for pe_host_ctrl against a 4x4 behavioural pe_array model.
module tb_pe_host_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid;
   logic       req_ready;
   logic [1:0] req_op;
   logic [1:0] req_x;
   logic [1:0] req_y;
   logic [0:0] req_data;
   logic       rsp_valid;
   logic [0:0] rsp_data;
   logic       rsp_err;
   logic [1:0] adr_x;
   logic [1:0] adr_y;
   logic [1:0] opcode;
   logic [0:0] vali;
   logic [0:0] valo = 1'b0;
   logic       written;

   int checks = 0;
   int errors = 0;

   // array model controls
   logic m_en;
   int   m_lat;
   int   m_hold;
   int   cnt;
   int   hcnt;
   logic mem [16];
   int   wlog [$];

   always #5 clk = ~clk;

   pe_host_ctrl #(
      .N_PX_BITS     (2),
      .N_PY_BITS     (2),
      .PE_CMD_BITS   (2),
      .PE_STATE_BITS (1),
      .TIMEOUT_CYC   (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_x     (req_x),
      .req_y     (req_y),
      .req_data  (req_data),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .adr_x     (adr_x),
      .adr_y     (adr_y),
      .opcode    (opcode),
      .vali      (vali),
      .valo      (valo),
      .written   (written)
   );

   // Array model: written rises m_lat cycles after a non-NOP opcode, stays
   // high until m_hold+1 cycles of NOP have been seen.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         written <= 1'b0;
         cnt     <= 0;
         hcnt    <= 0;
      end else if (opcode != 2'd0) begin
         if (!written && m_en) begin
            if (cnt == m_lat - 1) begin
               written <= 1'b1;
               if (opcode == 2'd1) begin
                  mem[{adr_y, adr_x}] <= vali[0];
                  wlog.push_back(int'({adr_y, adr_x}));
               end else if (opcode == 2'd2) begin
                  valo <= mem[{adr_y, adr_x}];
               end
            end else begin
               cnt <= cnt + 1;
            end
         end
      end else begin
         cnt <= 0;
         if (written) begin
            if (hcnt == m_hold) begin
               written <= 1'b0;
               hcnt    <= 0;
            end else begin
               hcnt <= hcnt + 1;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Present a request at a negedge; returns just after the accept edge.
   task automatic send(input logic [1:0] op, input logic [1:0] x, input logic [1:0] y,
                       input logic d);
      req_valid = 1'b1;
      req_op    = op;
      req_x     = x;
      req_y     = y;
      req_data  = d;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp(input string tag);
      int n = 0;
      while (rsp_valid !== 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(rsp_valid), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int ones;
      int pulses;
      int n;
      rst = 1'b1; req_valid = 1'b0; req_op = '0; req_x = '0; req_y = '0; req_data = '0;
      m_en = 1'b1; m_lat = 2; m_hold = 0;
      for (int i = 0; i < 16; i++) mem[i] = 1'b0;
      repeat (2) @(negedge clk);

      // reset state
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_data", 32'(rsp_data), 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      chk("rst_adr", 32'({adr_y, adr_x}), 32'd0);
      chk("rst_opcode", 32'(opcode), 32'd0);
      chk("rst_vali", 32'(vali), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // WRITE (2,3)=1, written 2 cycles after issue
      send(2'd0, 2'd2, 2'd3, 1'b1);
      chk("wr_opcode", 32'(opcode), 32'd1);
      chk("wr_adr_x", 32'(adr_x), 32'd2);
      chk("wr_adr_y", 32'(adr_y), 32'd3);
      chk("wr_vali", 32'(vali), 32'd1);
      chk("wr_busy", 32'(req_ready), 32'd0);
      repeat (2) @(negedge clk);
      chk("wr_hold_opcode", 32'(opcode), 32'd1);
      @(negedge clk);
      chk("wr_gap_nop", 32'(opcode), 32'd0);
      @(negedge clk);
      chk("wr_rsp_early", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      chk("wr_rsp_at5", 32'(rsp_valid), 32'd1);
      chk("wr_rsp_err", 32'(rsp_err), 32'd0);
      @(negedge clk);
      chk("wr_idle", 32'(req_ready), 32'd1);
      chk("wr_mem", 32'(mem[14]), 32'd1);

      // READ back written and unwritten cells
      send(2'd1, 2'd2, 2'd3, 1'b0);
      chk("rd_opcode", 32'(opcode), 32'd2);
      wait_rsp("rd23_rsp");
      chk("rd23_data", 32'(rsp_data), 32'd1);
      @(negedge clk);
      send(2'd1, 2'd1, 2'd1, 1'b0);
      wait_rsp("rd11_rsp");
      chk("rd11_data", 32'(rsp_data), 32'd0);
      chk("rd11_err", 32'(rsp_err), 32'd0);
      @(negedge clk);

      // FILL data=1: 16 raster-order writes, one response
      m_lat = 1;
      wlog.delete();
      send(2'd2, 2'd3, 2'd2, 1'b1);
      wait_rsp("fill_rsp");
      chk("fill_err", 32'(rsp_err), 32'd0);
      chk("fill_count", 32'(wlog.size()), 32'd16);
      for (int i = 0; i < wlog.size() && i < 16; i++) chk("fill_order", 32'(wlog[i]), 32'(i));
      ones = 0;
      for (int i = 0; i < 16; i++) ones += int'(mem[i]);
      chk("fill_cells", 32'(ones), 32'd16);
      pulses = 0;
      repeat (5) begin
         @(negedge clk);
         pulses += int'(rsp_valid);
      end
      chk("fill_one_rsp", 32'(pulses), 32'd0);

      // timeout: written never returned, TIMEOUT_CYC=16
      m_en = 1'b0;
      send(2'd0, 2'd1, 2'd0, 1'b1);
      repeat (16) @(negedge clk);
      chk("tmo_still_wait", 32'(opcode), 32'd1);
      @(negedge clk);
      chk("tmo_gap_nop", 32'(opcode), 32'd0);
      chk("tmo_rsp_early", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      chk("tmo_rsp", 32'(rsp_valid), 32'd1);
      chk("tmo_err", 32'(rsp_err), 32'd1);
      chk("tmo_data", 32'(rsp_data), 32'd0);
      @(negedge clk);
      chk("tmo_idle", 32'(req_ready), 32'd1);
      chk("tmo_nop", 32'(opcode), 32'd0);
      m_en = 1'b1;

      // async reset during FILL at cell 5
      m_lat = 2;
      send(2'd2, 2'd0, 2'd0, 1'b0);
      n = 0;
      while (!(adr_x == 2'd1 && adr_y == 2'd1 && opcode == 2'd1) && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("rstf_reach5", 32'(n < 500), 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("rstf_nop", 32'(opcode), 32'd0);
      chk("rstf_ready", 32'(req_ready), 32'd1);
      chk("rstf_adr", 32'({adr_y, adr_x}), 32'd0);
      chk("rstf_vali", 32'(vali), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      repeat (30) begin
         @(negedge clk);
         pulses += int'(rsp_valid);
      end
      chk("rstf_no_rsp", 32'(pulses), 32'd0);
      chk("rstf_cell4", 32'(mem[4]), 32'd0);
      chk("rstf_cell15", 32'(mem[15]), 32'd1);
      send(2'd0, 2'd3, 2'd3, 1'b0);
      wait_rsp("rstf_wr_rsp");
      chk("rstf_wr_err", 32'(rsp_err), 32'd0);
      @(negedge clk);
      chk("rstf_wr_mem", 32'(mem[15]), 32'd0);

      // STEP with a held follow-on request; written held in GAP
      m_lat = 1;
      m_hold = 2;
      req_valid = 1'b1;
      req_op = 2'd3; req_x = 2'd3; req_y = 2'd3; req_data = 1'b1;
      @(negedge clk);
      chk("st_opcode", 32'(opcode), 32'd3);
      chk("st_adr", 32'({adr_y, adr_x}), 32'd0);
      chk("st_vali", 32'(vali), 32'd0);
      req_op = 2'd0; req_x = 2'd1; req_y = 2'd2; req_data = 1'b1;
      @(negedge clk);
      chk("st_wait_busy", 32'(req_ready), 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("st_gap_nop", 32'(opcode), 32'd0);
         chk("st_gap_busy", 32'({req_ready, rsp_valid}), 32'd0);
      end
      @(negedge clk);
      chk("st_rsp", 32'(rsp_valid), 32'd1);
      chk("st_rsp_busy", 32'(req_ready), 32'd0);
      @(negedge clk);
      chk("st_idle_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
      chk("st_next_opcode", 32'(opcode), 32'd1);
      chk("st_next_adr", 32'({adr_y, adr_x}), 32'h9);
      wait_rsp("st_next_rsp");
      chk("st_next_err", 32'(rsp_err), 32'd0);
      @(negedge clk);
      chk("st_next_mem", 32'(mem[9]), 32'd1);
      m_hold = 0;

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
